// File: rtl/timebase_tick_gen_pkg.sv
// Shared definitions for the timebase tick generator: FSM state encoding,
// default board-build parameter values and a small edge-detect helper.
package timebase_tick_gen_pkg;

  // Board-build defaults
  localparam int DEF_CNT_W    = 27;
  localparam int DEF_BASE_TAP = 17;
  localparam int DEF_DEB_W    = 20;

  // Run/pause state encoding
  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } tb_state_t;

  // Rising-edge detect between a level and its one-cycle-delayed copy
  function automatic logic rise_detect(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/timebase_tick_gen_switch_debouncer.sv
// Two-flop synchroniser followed by a saturating-window debouncer.
// The stable output only follows the synchronised input after it has
// differed from the current stable value for DEB_MAX+1 consecutive cycles.
module switch_debouncer
  import timebase_tick_gen_pkg::*;
#(
  parameter int DEB_W = DEF_DEB_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam logic [DEB_W-1:0] DEB_MAX = '1;

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [DEB_W-1:0] r_cnt;

  // Bring the asynchronous raw input into the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only after it has persisted for the full window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_s2 == r_stable) begin
      r_cnt    <= '0;
    end else if (r_cnt == DEB_MAX) begin
      r_stable <= r_s2;
      r_cnt    <= '0;
    end else begin
      r_cnt    <= r_cnt + DEB_W'(1);
    end
  end

  assign stable = r_stable;

endmodule

// File: rtl/timebase_tick_gen.sv
// Timebase for the ripple counter: prescaler with selectable tap, a
// single-cycle tick, a 50%-duty slow clock, and debounced run/step controls.
module timebase_tick_gen
  import timebase_tick_gen_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int BASE_TAP = DEF_BASE_TAP,
  parameter int DEB_W    = DEF_DEB_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_sw,
  input  logic       step_btn,
  input  logic [2:0] rate_sel,
  output logic       tick,
  output logic       slow_clk,
  output logic       running
);

  logic             w_run_db;
  logic             w_step_db;
  logic             w_step_pulse;
  logic             w_rate_chg;
  logic [31:0]      w_tap;
  logic [CNT_W-1:0] w_mask;
  tb_state_t        w_next_state;
  logic [CNT_W-1:0] w_presc_next;
  logic             w_tick_next;

  tb_state_t        r_state;
  logic [CNT_W-1:0] r_presc;
  logic [2:0]       r_rate_q;
  logic             r_step_q;
  logic             r_tick;
  logic             r_slow;
  logic             r_running;

  switch_debouncer #(.DEB_W(DEB_W)) u_run_db (
    .clk    (clk),
    .reset  (reset),
    .raw    (run_sw),
    .stable (w_run_db)
  );

  switch_debouncer #(.DEB_W(DEB_W)) u_step_db (
    .clk    (clk),
    .reset  (reset),
    .raw    (step_btn),
    .stable (w_step_db)
  );

  assign w_step_pulse = rise_detect(w_step_db, r_step_q);
  assign w_rate_chg   = (rate_sel != r_rate_q);
  assign w_tap        = 32'(BASE_TAP) + 32'(r_rate_q);

  // Low-order prescaler bits that must all be 1 for a tick; a tap at or
  // beyond CNT_W simply uses the whole prescaler
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < CNT_W; i++) begin
      w_mask[i] = (32'(i) < w_tap);
    end
  end

  // Run/pause transition driven by the debounced run switch
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_PAUSE: w_next_state = w_run_db ? ST_RUN : ST_PAUSE;
      ST_RUN:   w_next_state = w_run_db ? ST_RUN : ST_PAUSE;
      default:  w_next_state = ST_PAUSE;
    endcase
  end

  // Prescaler advance and tick decision; a rate change restarts the period
  always_comb begin
    w_presc_next = r_presc;
    w_tick_next  = 1'b0;
    if (w_rate_chg) begin
      w_presc_next = '0;
      w_tick_next  = 1'b0;
    end else if (r_state == ST_RUN) begin
      w_presc_next = r_presc + CNT_W'(1);
      w_tick_next  = ((r_presc & w_mask) == w_mask);
    end else begin
      w_presc_next = r_presc;
      w_tick_next  = w_step_pulse;
    end
  end

  // State, prescaler and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_PAUSE;
      r_presc   <= '0;
      r_rate_q  <= 3'd0;
      r_step_q  <= 1'b0;
      r_tick    <= 1'b0;
      r_slow    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_presc   <= w_presc_next;
      r_rate_q  <= rate_sel;
      r_step_q  <= w_step_db;
      r_tick    <= w_tick_next;
      r_slow    <= r_slow ^ w_tick_next;
      r_running <= (w_next_state == ST_RUN);
    end
  end

  assign tick     = r_tick;
  assign slow_clk = r_slow;
  assign running  = r_running;

endmodule

// File: tb/tb_timebase_tick_gen.sv
// Scoreboard bench for timebase_tick_gen: a behavioural model predicts the
// outputs after every clock edge, a negedge monitor pops and compares.
module tb_timebase_tick_gen;

  localparam int CNT_W    = 8;
  localparam int BASE_TAP = 2;
  localparam int DEB_W    = 2;
  localparam int DEB_MAX  = (1 << DEB_W) - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run_sw = 1'b0;
  logic       step_btn = 1'b0;
  logic [2:0] rate_sel = 3'd0;
  logic       tick;
  logic       slow_clk;
  logic       running;

  timebase_tick_gen #(.CNT_W(CNT_W), .BASE_TAP(BASE_TAP), .DEB_W(DEB_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .rate_sel (rate_sel),
    .tick     (tick),
    .slow_clk (slow_clk),
    .running  (running)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic t; logic s; logic r; } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit run_h[$];
  bit step_h[$];
  bit m_run_st, m_step_st, m_step_prev, m_state, m_slow;
  int m_run_diff, m_step_diff, m_presc, m_rate_q;

  // value seen at the end of the synchroniser: the sample from two edges ago
  function automatic bit sync_out(input bit h[$]);
    return (h.size() >= 2) ? h[h.size()-2] : 1'b0;
  endfunction

  // a new level is accepted once it has disagreed for DEB_MAX+1 edges in a row
  task automatic deb(input bit s2, inout bit st, inout int run_len);
    if (s2 != st) begin
      run_len++;
      if (run_len == DEB_MAX + 1) begin
        st      = s2;
        run_len = 0;
      end
    end else begin
      run_len = 0;
    end
  endtask

  task automatic model_edge();
    bit rs2, ss2, pulse, nxt, t;
    int period;
    if (reset !== 1'b1) begin
      run_h.delete(); step_h.delete();
      m_run_st = 0; m_step_st = 0; m_step_prev = 0; m_state = 0; m_slow = 0;
      m_run_diff = 0; m_step_diff = 0; m_presc = 0; m_rate_q = 0;
      q.push_back(exp_t'(3'b000));
      return;
    end
    rs2    = sync_out(run_h);
    ss2    = sync_out(step_h);
    pulse  = m_step_st && !m_step_prev;
    nxt    = m_run_st;
    period = 1 << (BASE_TAP + m_rate_q);
    if (int'(rate_sel) != m_rate_q) begin
      m_presc = 0;
      t = 0;
    end else if (m_state) begin
      t = ((m_presc % period) == period - 1);
      m_presc = (m_presc + 1) % (1 << CNT_W);
    end else begin
      t = pulse;
    end
    m_slow      = m_slow ^ t;
    m_state     = nxt;
    m_rate_q    = int'(rate_sel);
    m_step_prev = m_step_st;
    deb(rs2, m_run_st, m_run_diff);
    deb(ss2, m_step_st, m_step_diff);
    run_h.push_back(run_sw);
    step_h.push_back(step_btn);
    if (run_h.size() > 2) void'(run_h.pop_front());
    if (step_h.size() > 2) void'(step_h.pop_front());
    q.push_back(exp_t'({t, m_slow, nxt}));
  endtask

  // ---------------- monitor ----------------
  int   cyc_cnt = 0, tick_cnt = 0, run_cyc = 0, last_tick = 0, tick_gap = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    cyc_cnt++;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("tick",     32'(tick),     32'(mon_e.t));
      chk("slow_clk", 32'(slow_clk), 32'(mon_e.s));
      chk("running",  32'(running),  32'(mon_e.r));
    end
    if (tick === 1'b1) begin
      tick_cnt++;
      tick_gap  = cyc_cnt - last_tick;
      last_tick = cyc_cnt;
    end
    if (running === 1'b1) run_cyc++;
  end

  // one clock: model the edge, then return just after the monitor's negedge
  task automatic cyc1();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  int base_t, base_r, lat, c0;

  initial begin
    // 1. reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      run_sw   = 1'($urandom);
      step_btn = 1'($urandom);
      rate_sel = 3'($urandom_range(0, 6));
      cyc1();
    end
    chk("reset tick", 32'(tick), 32'd0);
    chk("reset slow", 32'(slow_clk), 32'd0);
    chk("reset running", 32'(running), 32'd0);
    run_sw = 1'b0; step_btn = 1'b0; rate_sel = 3'd0;
    reset = 1'b1;
    base_t = tick_cnt; base_r = run_cyc;
    repeat (10) cyc1();
    chk("idle ticks", 32'(tick_cnt - base_t), 32'd0);
    chk("idle running", 32'(run_cyc - base_r), 32'd0);

    // 2. run latency and base period
    run_sw = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      cyc1();
      if (lat == 0 && running === 1'b1) lat = n;
    end
    chk("run latency", 32'(lat), 32'((1 << DEB_W) + 3));
    repeat (20) cyc1();
    chk("tick period tap2", 32'(tick_gap), 32'd4);

    // 3. glitch rejection
    run_sw = 1'b0;
    repeat (15) cyc1();
    chk("paused", 32'(running), 32'd0);
    base_r = run_cyc;
    run_sw = 1'b1;
    repeat (3) cyc1();
    run_sw = 1'b0;
    repeat (15) cyc1();
    chk("run glitch", 32'(run_cyc - base_r), 32'd0);
    base_t = tick_cnt;
    step_btn = 1'b1;
    cyc1();
    step_btn = 1'b0;
    repeat (15) cyc1();
    chk("step glitch", 32'(tick_cnt - base_t), 32'd0);

    // 4. single step in pause, then same press while running
    base_t = tick_cnt;
    step_btn = 1'b1;
    repeat (10) cyc1();
    step_btn = 1'b0;
    repeat (10) cyc1();
    chk("single step", 32'(tick_cnt - base_t), 32'd1);
    run_sw = 1'b1;
    repeat (12) cyc1();
    step_btn = 1'b1;
    repeat (10) cyc1();
    step_btn = 1'b0;
    repeat (10) cyc1();

    // 5. rate change mid-period
    repeat ($urandom_range(1, 3)) cyc1();
    c0 = cyc_cnt;
    rate_sel = 3'd3;
    repeat (40) cyc1();
    chk("first tick after rate", 32'(last_tick - (c0 + 1)), 32'd32);
    repeat (32) cyc1();
    chk("tick period tap5", 32'(tick_gap), 32'd32);

    // 6. pause / resume
    rate_sel = 3'd0;
    repeat ($urandom_range(2, 5)) cyc1();
    run_sw = 1'b0;
    repeat (10) cyc1();
    base_t = tick_cnt;
    repeat (50) cyc1();
    chk("pause ticks", 32'(tick_cnt - base_t), 32'd0);
    run_sw = 1'b1;
    repeat (40) cyc1();

    // random soak
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 14) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 149) == 0) rate_sel = 3'($urandom_range(0, 6));
      if ($urandom_range(0, 799) == 0) reset = 1'b0;
      else reset = 1'b1;
      cyc1();
    end
    reset = 1'b1;
    cyc1();
    chk("queue drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
